// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8
//
// Eight-requester round-robin arbiter with grant hold and optional timeout.
// A request seen while idle is granted on the next edge; the grant is then held
// until the owner pulses done, the owner drops its request, or the hold timer
// expires. Every grant is followed by at least one idle cycle, and the search
// pointer moves to owner+1 so that the last owner gets the lowest priority.
//
// The grant/grant_valid pair feeds an 8-to-3 one-hot encoder directly. grant
// is therefore always zero or one-hot, and grant_valid is always equal to
// |grant. Both are registered.
//
// Parameters:
//   TIMEOUT      maximum number of cycles a grant stays visible before a
//                forced release (0 disables the timeout)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   req[7:0]     request vector, bit i = requester i
//   done         single-cycle release pulse from the current owner
//   grant[7:0]   registered one-hot grant, all-zero when idle
//   grant_valid  high exactly when grant is non-zero
//   timeout_err  one-cycle pulse when the timer alone forced the release
//
// Handshake: req[i] is a level that requester i holds for as long as it wants
// the resource. A grant is only ever issued from IDLE, so a requester sees its
// grant bit rise one cycle after its request was sampled, and sees it fall one
// cycle after it raised done, dropped req, or hit the timeout. done is only
// looked at while a grant is held; in IDLE it has no effect.
// -----------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic       timeout_err
);

    // Counter must hold values up to TIMEOUT, with at least one bit.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Value of the counter during the last cycle a grant may be visible.
    localparam int TMO_LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_LAST_INT);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q;
    logic [7:0]      grant_q;
    logic            grant_valid_q;
    logic            timeout_err_q;
    logic [2:0]      ptr_q;
    logic [2:0]      owner_q;
    logic [CW-1:0]   cnt_q;

    // Arbitration result for the current cycle (only used in IDLE).
    logic            win_found_d;
    logic [2:0]      win_idx_d;
    logic [2:0]      scan_idx;

    // Release causes while holding a grant.
    logic            owner_req_d;
    logic            tmo_hit_d;
    logic            release_d;
    logic            tmo_only_d;
    logic [2:0]      ptr_next_d;

    // Scan ptr, ptr+1, ... wrapping mod 8; the first set bit wins. The 3-bit
    // add wraps naturally, so no explicit modulo is needed.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = 3'd0;
        scan_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!win_found_d && req[scan_idx]) begin
                win_found_d = 1'b1;
                win_idx_d   = scan_idx;
            end
        end
    end

    always_comb begin
        owner_req_d = req[owner_q];
        tmo_hit_d   = (TIMEOUT != 0) && (cnt_q == TMO_LAST);
        release_d   = done || !owner_req_d || tmo_hit_d;
        // A timeout only counts as an error when nothing else released the
        // grant on the same edge.
        tmo_only_d  = tmo_hit_d && !done && owner_req_d;
        // owner 7 wraps to 0 through the 3-bit add.
        ptr_next_d  = owner_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 8'h00;
            grant_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
            ptr_q         <= 3'd0;
            owner_q       <= 3'd0;
            cnt_q         <= '0;
        end else begin
            // timeout_err is a pulse; it is only raised on the release edge.
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        grant_q       <= 8'b0000_0001 << win_idx_d;
                        grant_valid_q <= 1'b1;
                        owner_q       <= win_idx_d;
                        cnt_q         <= '0;
                        state_q       <= HOLD;
                    end else begin
                        grant_q       <= 8'h00;
                        grant_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (release_d) begin
                        // Going through IDLE guarantees the idle gap before
                        // the next grant and defers arbitration one cycle.
                        grant_q       <= 8'h00;
                        grant_valid_q <= 1'b0;
                        timeout_err_q <= tmo_only_d;
                        ptr_q         <= ptr_next_d;
                        state_q       <= IDLE;
                    end else if (cnt_q != CNT_MAX) begin
                        // Saturate instead of wrapping (matters when the
                        // timeout is disabled).
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    grant_q       <= 8'h00;
                    grant_valid_q <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

  localparam int TMO = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       grant_valid;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  logic prev_err = 1'b0;
  logic inv_en   = 1'b0;

  rr_arbiter8 #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout_err (timeout_err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if (!(grant == 8'h00 || $onehot(grant))) begin
        errors++;
        $display("FAIL inv_onehot: grant=%h required zero or one-hot", grant);
      end
      checks++;
      if (grant_valid !== (|grant)) begin
        errors++;
        $display("FAIL inv_valid: grant_valid=%b required %b", grant_valid, |grant);
      end
      checks++;
      if (timeout_err && prev_err) begin
        errors++;
        $display("FAIL inv_err_pulse: timeout_err high two cycles, required single pulse");
      end
      checks++;
      if (timeout_err && grant_valid) begin
        errors++;
        $display("FAIL inv_err_idle: timeout_err=1 with grant_valid=1, required grant_valid=0");
      end
      prev_err = timeout_err;
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    cyc(); cyc();
    inv_en = 1'b1;
    checks++;
    if ({grant, grant_valid, timeout_err} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got %h/%b/%b required 00/0/0", grant, grant_valid, timeout_err);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if ({grant, grant_valid} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle: got %h/%b required 00/0", grant, grant_valid);
    end
  endtask

  // req=10 held, done on the 4th grant cycle (counter = TMO-1 too, so no error)
  task automatic test_single();
    req = 8'h10;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      checks++;
      if ({grant, grant_valid, timeout_err} !== {8'h10, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL single_c%0d: got %h/%b/%b required 10/1/0", c, grant, grant_valid, timeout_err);
      end
    end
    done = 1'b1;
    cyc();
    done = 1'b0;
    req  = 8'h00;
    checks++;
    if ({grant, grant_valid, timeout_err} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_release: got %h/%b/%b required 00/0/0", grant, grant_valid, timeout_err);
    end
    cyc();
    checks++;
    if (grant !== 8'h00) begin
      errors++;
      $display("FAIL single_idle: grant=%h required 00", grant);
    end
  endtask

  // ptr=5 after owner 4: req=09 -> bit 0 wins by wrap. Release by dropping req
  // gives ptr=1; then req=81 -> bit 7 wins; release gives ptr=0; req=81 -> 01.
  task automatic test_fairness();
    req = 8'h09;
    cyc();
    checks++;
    if (grant !== 8'h01) begin
      errors++;
      $display("FAIL fair_wrap: grant=%h required 01", grant);
    end
    req = 8'h00;
    cyc();
    checks++;
    if ({grant, timeout_err} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL fair_drop_release: got %h/%b required 00/0", grant, timeout_err);
    end
    req = 8'h81;
    cyc();
    checks++;
    if (grant !== 8'h80) begin
      errors++;
      $display("FAIL fair_ptr1: grant=%h required 80", grant);
    end
    done = 1'b1;
    cyc();
    done = 1'b0;
    checks++;
    if (grant !== 8'h00) begin
      errors++;
      $display("FAIL fair_release7: grant=%h required 00", grant);
    end
    cyc();
    checks++;
    if (grant !== 8'h01) begin
      errors++;
      $display("FAIL fair_ptr_wrap: grant=%h required 01", grant);
    end
    req = 8'h00;
    cyc();
    cyc();
  endtask

  // After reset, req=FF with done on each grant's first cycle.
  task automatic test_rotation();
    logic [7:0] e;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      e = 8'h01 << (k % 8);
      cyc();
      checks++;
      if ({grant, grant_valid} !== {e, 1'b1}) begin
        errors++;
        $display("FAIL rot_grant%0d: got %h/%b required %h/1", k, grant, grant_valid, e);
      end
      done = 1'b1;
      cyc();
      done = 1'b0;
      checks++;
      if ({grant, grant_valid} !== {8'h00, 1'b0}) begin
        errors++;
        $display("FAIL rot_gap%0d: got %h/%b required 00/0", k, grant, grant_valid);
      end
    end
    req = 8'h00;
    cyc();
  endtask

  // ptr=1 here. req=04 held: 4 visible cycles, forced release with error,
  // regrant, then done coinciding with expiry, then req drop coinciding.
  task automatic test_timeout();
    req = 8'h04;
    for (int c = 1; c <= TMO; c++) begin
      cyc();
      checks++;
      if ({grant, timeout_err} !== {8'h04, 1'b0}) begin
        errors++;
        $display("FAIL tmo_hold_c%0d: got %h/%b required 04/0", c, grant, timeout_err);
      end
    end
    cyc();
    checks++;
    if ({grant, grant_valid, timeout_err} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL tmo_forced: got %h/%b/%b required 00/0/1", grant, grant_valid, timeout_err);
    end
    cyc();
    checks++;
    if ({grant, timeout_err} !== {8'h04, 1'b0}) begin
      errors++;
      $display("FAIL tmo_regrant: got %h/%b required 04/0", grant, timeout_err);
    end
    cyc(); cyc(); cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    checks++;
    if ({grant, timeout_err} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL tmo_coincident_done: got %h/%b required 00/0", grant, timeout_err);
    end
    cyc();
    checks++;
    if (grant !== 8'h04) begin
      errors++;
      $display("FAIL tmo_regrant2: grant=%h required 04", grant);
    end
    cyc(); cyc(); cyc();
    req = 8'h00;
    cyc();
    checks++;
    if ({grant, timeout_err} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL tmo_coincident_drop: got %h/%b required 00/0", grant, timeout_err);
    end
    cyc();
  endtask

  // ptr=3 here, so req=C0 grants owner 6. Reset mid-grant, then ptr=0 -> 40.
  task automatic test_reset_mid_grant();
    req = 8'hC0;
    cyc();
    checks++;
    if (grant !== 8'h40) begin
      errors++;
      $display("FAIL rmg_grant: grant=%h required 40", grant);
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({grant, grant_valid, timeout_err} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rmg_clear: got %h/%b/%b required 00/0/0", grant, grant_valid, timeout_err);
    end
    cyc();
    checks++;
    if (grant !== 8'h40) begin
      errors++;
      $display("FAIL rmg_ptr0: grant=%h required 40", grant);
    end
    req = 8'h00;
    cyc();
    cyc();
  endtask

  // done in IDLE does not block or alter a grant. ptr=7 after owner 6.
  task automatic test_done_idle();
    done = 1'b1;
    cyc();
    checks++;
    if (grant !== 8'h00) begin
      errors++;
      $display("FAIL idle_done_noreq: grant=%h required 00", grant);
    end
    req = 8'h88;
    cyc();
    done = 1'b0;
    checks++;
    if (grant !== 8'h80) begin
      errors++;
      $display("FAIL idle_done_grant: grant=%h required 80", grant);
    end
    cyc();
    checks++;
    if (grant !== 8'h80) begin
      errors++;
      $display("FAIL idle_done_hold: grant=%h required 80", grant);
    end
    req = 8'h00;
    cyc();
    cyc();
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_rotation();
    test_timeout();
    test_reset_mid_grant();
    test_done_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
